// File: rtl/dcache_pkg.sv
// Shared types and helpers for the 2-way set-associative L1 data cache.
// Derived widths below are for the default geometry; modules re-derive from their own parameters.
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_MISS        = 3'd1,
        S_WRITEBACK   = 3'd2,
        S_REFILL      = 3'd3,
        S_REFILL_DONE = 3'd4
    } state_t;

    function automatic int dc_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LINE_BYTES = 32;
    localparam int DEF_SETS       = 32;
    localparam int OFF_W = dc_log2(DEF_LINE_BYTES);
    localparam int IDX_W = dc_log2(DEF_SETS);
    localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W;

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/dirty/tag/data arrays, combinational lookup and
// a registered write port that either fills a whole line or merges bytes of one word.
module dcache_way
    import dcache_pkg::*;
#(
    parameter  int LINE_BYTES = 32,
    parameter  int SETS       = 32,
    parameter  int TW         = 22,
    localparam int LINE_W     = 8 * LINE_BYTES,
    localparam int WORDS      = LINE_BYTES / 4,
    localparam int IW         = dc_log2(SETS),
    localparam int WW         = (WORDS > 1) ? dc_log2(WORDS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [IW-1:0]     i_idx,
    input  logic [TW-1:0]     i_tag,
    input  logic [WW-1:0]     i_word,
    input  logic              i_fill,
    input  logic [LINE_W-1:0] i_fill_line,
    input  logic              i_wr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_be,
    output logic              o_hit,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TW-1:0]     o_tag,
    output logic [LINE_W-1:0] o_line,
    output logic [31:0]       o_word
);

    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [TW-1:0]     r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];
    assign o_hit   = o_valid && (o_tag == i_tag);

    always_comb begin
        o_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (WORDS == 1 || i_word == WW'(w)) o_word = o_line[w*32 +: 32];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_wr) begin
            // a store with no strobes still marks the line dirty
            r_dirty[i_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_fill) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_fill_line;
        end else if (i_wr) begin
            for (int w = 0; w < WORDS; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if ((WORDS == 1 || i_word == WW'(w)) && i_be[b])
                        r_data[i_idx][w*32 + b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back, write-allocate L1 data cache with true-LRU
// replacement, byte-strobed stores and saturating hit/miss counters.
module dcache_2way_top
    import dcache_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int LINE_BYTES = 32,
    parameter  int SETS       = 32,
    parameter  int CNT_W      = 32,
    localparam int LINE_W     = 8 * LINE_BYTES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [31:0]       p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [3:0]        p1_be_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int OW    = dc_log2(LINE_BYTES);
    localparam int IW    = dc_log2(SETS);
    localparam int TW    = ADDR_W - IW - OW;
    localparam int WORDS = LINE_BYTES / 4;
    localparam int WW    = (WORDS > 1) ? dc_log2(WORDS) : 1;

    logic [TW-1:0] w_tag;
    logic [IW-1:0] w_idx;
    logic [WW-1:0] w_word;
    logic          w_unused;

    assign w_tag    = p1_addr_i[ADDR_W-1 -: TW];
    assign w_idx    = p1_addr_i[OW +: IW];
    assign w_word   = (WORDS > 1) ? p1_addr_i[2 +: WW] : '0;
    assign w_unused = &{1'b0, p1_addr_i[1:0]};

    state_t            r_state;
    logic [SETS-1:0]   r_lru;
    logic              r_victim;
    logic              r_mem_en;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_data;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic [1:0]             w_hit, w_valid, w_dirty, w_fill, w_wr;
    logic [1:0][TW-1:0]     w_vtag;
    logic [1:0][LINE_W-1:0] w_line;
    logic [1:0][31:0]       w_rword;

    logic w_req, w_any_hit, w_idle, w_vic;

    assign w_req     = p1_MemRead_i | p1_MemWrite_i;
    assign w_any_hit = |w_hit;
    assign w_idle    = (r_state == S_IDLE);

    for (genvar g = 0; g < 2; g++) begin : g_way
        assign w_wr[g]   = w_idle & p1_MemWrite_i & w_hit[g];
        assign w_fill[g] = (r_state == S_REFILL) & mem_ack_i & (r_victim == 1'(g));

        dcache_way #(
            .LINE_BYTES (LINE_BYTES),
            .SETS       (SETS),
            .TW         (TW)
        ) u_way (
            .i_clk       (clk_i),
            .i_rst       (rst_i),
            .i_idx       (w_idx),
            .i_tag       (w_tag),
            .i_word      (w_word),
            .i_fill      (w_fill[g]),
            .i_fill_line (mem_data_i),
            .i_wr        (w_wr[g]),
            .i_wdata     (p1_data_i),
            .i_be        (p1_be_i),
            .o_hit       (w_hit[g]),
            .o_valid     (w_valid[g]),
            .o_dirty     (w_dirty[g]),
            .o_tag       (w_vtag[g]),
            .o_line      (w_line[g]),
            .o_word      (w_rword[g])
        );
    end

    // invalid ways are filled first; LRU only decides between two valid lines
    assign w_vic = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_idx]);

    assign p1_stall_o   = w_req & ~(w_any_hit & w_idle);
    assign p1_data_o    = w_hit[0] ? w_rword[0] : (w_hit[1] ? w_rword[1] : 32'h0);
    assign mem_enable_o = r_mem_en;
    assign mem_write_o  = r_mem_wr;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign hit_cnt_o    = r_hit_cnt;
    assign miss_cnt_o   = r_miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_lru      <= '0;
            r_victim   <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && w_any_hit) begin
                        r_lru[w_idx] <= w_hit[0];
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                    end else if (w_req) begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                        r_state <= S_MISS;
                    end
                end
                S_MISS: begin
                    r_victim <= w_vic;
                    r_mem_en <= 1'b1;
                    if (w_valid[w_vic] && w_dirty[w_vic]) begin
                        r_mem_wr   <= 1'b1;
                        r_mem_addr <= {w_vtag[w_vic], w_idx, {OW{1'b0}}};
                        r_mem_data <= w_line[w_vic];
                        r_state    <= S_WRITEBACK;
                    end else begin
                        r_mem_wr   <= 1'b0;
                        r_mem_addr <= {w_tag, w_idx, {OW{1'b0}}};
                        r_state    <= S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_mem_wr   <= 1'b0;
                        r_mem_addr <= {w_tag, w_idx, {OW{1'b0}}};
                        r_state    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        r_mem_en <= 1'b0;
                        r_state  <= S_REFILL_DONE;
                    end
                end
                S_REFILL_DONE: r_state <= S_IDLE;
                default:       r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dcache_2way_top.md
Name: dcache_2way_top

Overview:
- Parametrised successor to the direct-mapped L1 data cache: N-set, 2-way set-associative, write-back, write-allocate.
- Adds true-LRU replacement per set, per-byte write strobes and saturating hit/miss counters.
- Sits between the CPU MEM stage (p1_* port) and the line-wide data memory (mem_* port).
- Tag/valid/dirty and data storage are internal register arrays.

Parameters:
- ADDR_W, 32, byte-address width.
- LINE_BYTES, 32, bytes per line (power of 2, ≥4). LINE_W = 8*LINE_BYTES.
- SETS, 32, sets per way (power of 2, ≥2).
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- mem_data_i  in  LINE_W  refill line from memory.
- mem_ack_i  in  1  one-cycle pulse; memory transaction done.
- mem_data_o  out  LINE_W  victim line for write-back.
- mem_addr_o  out  ADDR_W  line-aligned address; offset bits are 0.
- mem_enable_o  out  1  request; held high until mem_ack_i.
- mem_write_o  out  1  1 = write-back, 0 = refill read.
- p1_data_i  in  32  store data.
- p1_addr_i  in  ADDR_W  byte address.
- p1_be_i  in  4  byte strobes for stores.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request. Never asserted together with p1_MemRead_i.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  stall the CPU.
- hit_cnt_o  out  CNT_W  requests that hit in IDLE.
- miss_cnt_o  out  CNT_W  misses detected.

Behaviour:
- Address split:
  - OFF_W = log2(LINE_BYTES), IDX_W = log2(SETS), TAG_W = ADDR_W - IDX_W - OFF_W.
  - Word select = addr[OFF_W-1:2]; addr[1:0] ignored.
- Hit: hit_w = valid_w & (tag_w == p1 tag); hit = hit0 | hit1.
  - Both ways never hold the same valid tag in one set.
- Stall: p1_stall_o = req & ~(hit & state == IDLE), where req = MemRead | MemWrite. Combinational.
- Load hit: p1_data_o = selected word of the hit way, combinational. p1_data_o = 0 when there is no hit.
- Store hit: at the clock edge, update only the bytes with p1_be_i set, and set dirty.
  - p1_be_i = 0 leaves data unchanged but still sets dirty.
- LRU, one bit per set, names the least-recently-used way. On any hit in IDLE, LRU <= the other way.
- States: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
- IDLE:
  - req & ~hit -> MISS; miss_cnt_o += 1.
  - req & hit -> stay; hit_cnt_o += 1.
- MISS: latch victim.
  - Victim = way0 if invalid, else way1 if invalid, else LRU way.
  - Victim valid & dirty -> WRITEBACK: mem_enable = 1, mem_write = 1, mem_addr = {victim tag, index, 0}, mem_data_o = victim line.
  - Otherwise -> REFILL: mem_enable = 1, mem_write = 0, mem_addr = {p1 tag, index, 0}.
- WRITEBACK: on mem_ack_i -> REFILL, same edge mem_write <= 0, mem_enable stays 1.
- REFILL: on mem_ack_i:
  - Victim line <= mem_data_i, tag <= p1 tag, valid <= 1, dirty <= 0.
  - mem_enable <= 0; -> REFILL_DONE.
- REFILL_DONE: -> IDLE. The request now hits; stall drops, and a store completes as a store hit.
  - The retried hit counts in hit_cnt_o, so one miss adds 1 to each counter.
- mem_ack_i is ignored in IDLE, MISS and REFILL_DONE.
- CPU holds p1_* stable while stalled; no other requirement on the CPU during a miss.
- Counters saturate at all-ones.
- Reset, including mid-transaction:
  - Next edge: state = IDLE; mem_enable_o, mem_write_o, mem_addr_o, mem_data_o = 0.
  - All valid, dirty and LRU bits = 0; counters = 0; data contents undefined.
  - An in-flight memory transaction is abandoned; a late mem_ack_i is ignored.

Decomposition:
- Package dcache_pkg holds:
  - State encoding (3-bit localparams).
  - The log2 helper function.
  - Derived-width localparams OFF_W, IDX_W, TAG_W.
- Sub-module dcache_way: one way's storage and compare logic.
  - valid/dirty/tag/data arrays.
  - Combinational read and hit_o.
  - Registered write with line-fill and byte-masked word-write modes.
  - Instantiated twice.
- Top holds the FSM, LRU array, victim select, memory muxes and counters.

Test Plan:
1. Reset, then load 0x0000_0040, memory line all 0xA5 -> one REFILL, mem_addr_o = 0x40, p1_data_o = 0xA5A5_A5A5; miss_cnt = 1, hit_cnt = 1.
2. Store 0xDEADBEEF, be = 4'b0011, to 0x44 after scenario 1 -> no stall cycle; a subsequent load of 0x44 returns 0xA5A5_BEEF.
3. Defaults (set 0 = 0x000/0x400/0x800); after loads of 0x000 and 0x400, load 0x000 again, then load 0x800 -> 0x400's way (LRU) is replaced, no write-back; 0x000 still hits.
4. Dirty 0x000 (store), then touch 0x400, then load 0x400 and load 0x800 -> WRITEBACK of the 0x000 line (mem_write_o = 1, addr 0x000, modified data) precedes REFILL of 0x800.
5. Assert rst_i during WRITEBACK with mem_enable_o high -> next edge mem_enable_o = 0, state IDLE; a following ack pulse is ignored; the next load misses.
6. CNT_W = 3, eight hits -> hit_cnt_o saturates at 7.
